// File: rtl/dc_useq_pkg.sv
// Shared definitions for the DC303 microsequencer: sequencer field opcodes
// and the run / map-wait state encoding.
package dc_useq_pkg;

  localparam logic [1:0] SEQ_NEXT = 2'b00;
  localparam logic [1:0] SEQ_MAP  = 2'b01;
  localparam logic [1:0] SEQ_CALL = 2'b10;
  localparam logic [1:0] SEQ_RET  = 2'b11;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    MAPW = 1'b1
  } useq_state_e;

endpackage

// File: rtl/dc_useq_if.sv
// MicROM read port: the sequencer drives the address, the ROM returns the
// next-address field and the microword combinationally.
interface dc_useq_if;

  logic [9:0]  rom_a;
  logic [8:0]  rom_ma;
  logic [15:0] rom_mc;

  modport master (output rom_a, input rom_ma, input rom_mc);
  modport slave  (input rom_a, output rom_ma, output rom_mc);

endinterface

// File: rtl/dc_ustack.sv
// Circular return-address LIFO. A push into a full stack overwrites the
// oldest entry; a pop from an empty stack is ignored.
module dc_ustack #(
  parameter int DEPTH = 2,
  parameter int W     = 9
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_r [DEPTH];
  logic [PW-1:0] wptr_r;
  logic [PW-1:0] wptr_inc_s;
  logic [PW-1:0] rptr_s;
  logic [CW-1:0] cnt_r;

  // Pointer arithmetic modulo DEPTH; the write pointer is one past the top.
  always_comb begin
    if (wptr_r == PW'(DEPTH - 1)) begin
      wptr_inc_s = {PW{1'b0}};
    end else begin
      wptr_inc_s = wptr_r + PW'(1);
    end
    if (wptr_r == {PW{1'b0}}) begin
      rptr_s = PW'(DEPTH - 1);
    end else begin
      rptr_s = wptr_r - PW'(1);
    end
  end

  assign top   = mem_r[rptr_s];
  assign full  = (cnt_r == CW'(DEPTH));
  assign empty = (cnt_r == {CW{1'b0}});

  // Storage, pointer and occupancy update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {W{1'b0}};
      end
      wptr_r <= {PW{1'b0}};
      cnt_r  <= {CW{1'b0}};
    end else if (push) begin
      mem_r[wptr_r] <= din;
      wptr_r        <= wptr_inc_s;
      if (!full) begin
        cnt_r <= cnt_r + CW'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end else if (pop && !empty) begin
      wptr_r <= rptr_s;
      cnt_r  <= cnt_r - CW'(1);
    end else begin
      wptr_r <= wptr_r;
      cnt_r  <= cnt_r;
    end
  end

endmodule

// File: rtl/dc_useq.sv
// DC303 microsequencer: addresses the MicROM, registers the microword and
// chooses the next uPC from ROM link, PLA map, return stack or trap vector.
module dc_useq
  import dc_useq_pkg::*;
#(
  parameter logic [8:0] RESET_VEC   = 9'h080,
  parameter logic [8:0] TRAP_VEC    = 9'h0C0,
  parameter int         STACK_DEPTH = 2,
  parameter int         SEQ_LSB     = 14
) (
  input  logic             clk,
  input  logic             reset_n,
  dc_useq_if.master        rom,
  input  logic             ax,
  input  logic             stall,
  input  logic [6:0]       pla_addr,
  input  logic             pla_valid,
  input  logic             trap_req,
  output logic             trap_ack,
  output logic [15:0]      mc_out,
  output logic             mc_valid,
  output logic [8:0]       upc,
  output logic             stk_err
);

  useq_state_e state_r, state_nxt_s;
  logic [1:0]  op_s;
  logic [8:0]  upc_r, upc_nxt_s, upc_inc_s;
  logic [15:0] mc_r, mc_nxt_s;
  logic        valid_r, valid_nxt_s;
  logic        ack_r, ack_nxt_s;
  logic        err_r, err_nxt_s;
  logic        push_s, pop_s;
  logic [8:0]  stk_top_s;
  logic        stk_full_s, stk_empty_s;

  assign rom.rom_a = {ax, upc_r};
  assign op_s      = rom.rom_mc[SEQ_LSB +: 2];
  assign upc_inc_s = upc_r + 9'd1;

  dc_ustack #(
    .DEPTH (STACK_DEPTH),
    .W     (9)
  ) u_stack (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push_s),
    .pop     (pop_s),
    .din     (upc_inc_s),
    .top     (stk_top_s),
    .full    (stk_full_s),
    .empty   (stk_empty_s)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Map wait is entered whenever a MAP word finds no valid PLA target.
  always_comb begin
    if (stall) begin
      state_nxt_s = state_r;
    end else if (trap_req) begin
      state_nxt_s = RUN;
    end else if ((op_s == SEQ_MAP) && !pla_valid) begin
      state_nxt_s = MAPW;
    end else begin
      state_nxt_s = RUN;
    end
  end

  // Next uPC, microword capture and stack control in priority order.
  always_comb begin
    upc_nxt_s   = upc_r;
    mc_nxt_s    = mc_r;
    valid_nxt_s = 1'b0;
    ack_nxt_s   = 1'b0;
    err_nxt_s   = err_r;
    push_s      = 1'b0;
    pop_s       = 1'b0;
    if (stall) begin
      valid_nxt_s = 1'b0;
    end else if (trap_req) begin
      mc_nxt_s    = rom.rom_mc;
      upc_nxt_s   = TRAP_VEC;
      valid_nxt_s = 1'b1;
      ack_nxt_s   = 1'b1;
    end else if ((op_s == SEQ_MAP) && !pla_valid) begin
      valid_nxt_s = 1'b0;
    end else begin
      mc_nxt_s    = rom.rom_mc;
      valid_nxt_s = 1'b1;
      case (op_s)
        SEQ_NEXT: upc_nxt_s = rom.rom_ma;
        SEQ_MAP:  upc_nxt_s = {2'b00, pla_addr};
        SEQ_CALL: begin
          push_s    = 1'b1;
          upc_nxt_s = rom.rom_ma;
          if (stk_full_s) begin
            err_nxt_s = 1'b1;
          end else begin
            err_nxt_s = err_r;
          end
        end
        SEQ_RET: begin
          if (stk_empty_s) begin
            upc_nxt_s = RESET_VEC;
            err_nxt_s = 1'b1;
          end else begin
            pop_s     = 1'b1;
            upc_nxt_s = stk_top_s;
          end
        end
        default: upc_nxt_s = rom.rom_ma;
      endcase
    end
  end

  // Registered sequencer outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      upc_r   <= RESET_VEC;
      mc_r    <= 16'h0000;
      valid_r <= 1'b0;
      ack_r   <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      upc_r   <= upc_nxt_s;
      mc_r    <= mc_nxt_s;
      valid_r <= valid_nxt_s;
      ack_r   <= ack_nxt_s;
      err_r   <= err_nxt_s;
    end
  end

  assign upc      = upc_r;
  assign mc_out   = mc_r;
  assign mc_valid = valid_r;
  assign trap_ack = ack_r;
  assign stk_err  = err_r;

endmodule

// File: tb/tb_dc_useq.sv
// Directed bench for dc_useq with a ROM image and a behavioural sequencer
// model compared against the DUT on every falling edge.
module tb_dc_useq;

  logic        clk;
  logic        reset_n;
  logic        ax, stall, pla_valid, trap_req;
  logic [6:0]  pla_addr;
  logic        trap_ack, mc_valid, stk_err;
  logic [15:0] mc_out;
  logic [8:0]  upc;

  logic [8:0]  rom_ma_t [1024];
  logic [15:0] rom_mc_t [1024];

  dc_useq_if rif ();
  assign rif.rom_ma = rom_ma_t[rif.rom_a];
  assign rif.rom_mc = rom_mc_t[rif.rom_a];

  dc_useq dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rom       (rif.master),
    .ax        (ax),
    .stall     (stall),
    .pla_addr  (pla_addr),
    .pla_valid (pla_valid),
    .trap_req  (trap_req),
    .trap_ack  (trap_ack),
    .mc_out    (mc_out),
    .mc_valid  (mc_valid),
    .upc       (upc),
    .stk_err   (stk_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic chk_en = 1'b0;

  // Model state: what the sequencer outputs must be after the pending edge.
  logic [8:0]  upc_m;
  logic [15:0] mc_m;
  logic        valid_m, ack_m, err_m;
  logic [8:0]  stk_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mreset();
    upc_m   = 9'h080;
    mc_m    = 16'h0000;
    valid_m = 1'b0;
    ack_m   = 1'b0;
    err_m   = 1'b0;
    stk_q.delete();
  endtask

  task automatic model_step();
    logic [9:0]  a;
    logic [15:0] w;
    logic [1:0]  op;
    ack_m   = 1'b0;
    valid_m = 1'b0;
    if (!stall) begin
      a  = {ax, upc_m};
      w  = rom_mc_t[a];
      op = w[15:14];
      if (trap_req) begin
        mc_m    = w;
        upc_m   = 9'h0C0;
        valid_m = 1'b1;
        ack_m   = 1'b1;
      end else if (!(op == 2'd1 && !pla_valid)) begin
        mc_m    = w;
        valid_m = 1'b1;
        if (op == 2'd0) begin
          upc_m = rom_ma_t[a];
        end else if (op == 2'd1) begin
          upc_m = {2'b00, pla_addr};
        end else if (op == 2'd2) begin
          stk_q.push_back(upc_m + 9'd1);
          if (stk_q.size() > 2) begin
            void'(stk_q.pop_front());
            err_m = 1'b1;
          end
          upc_m = rom_ma_t[a];
        end else if (stk_q.size() == 0) begin
          upc_m = 9'h080;
          err_m = 1'b1;
        end else begin
          upc_m = stk_q.pop_back();
        end
      end
    end
  endtask

  task automatic step(input logic st, input logic tr, input logic pv,
                      input logic [6:0] pa, input logic a);
    stall = st; trap_req = tr; pla_valid = pv; pla_addr = pa; ax = a;
    model_step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("upc",      32'(upc),       32'(upc_m));
      chk("mc_out",   32'(mc_out),    32'(mc_m));
      chk("mc_valid", 32'(mc_valid),  32'(valid_m));
      chk("trap_ack", 32'(trap_ack),  32'(ack_m));
      chk("stk_err",  32'(stk_err),   32'(err_m));
      chk("rom_a",    32'(rif.rom_a), 32'({ax, upc_m}));
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: run did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      rom_ma_t[i] = 9'(i + 1);
      rom_mc_t[i] = 16'(i) & 16'h3FFF;
    end
    rom_ma_t[10'h080] = 9'h085; rom_mc_t[10'h080] = 16'h0123;
    rom_ma_t[10'h085] = 9'h0A3; rom_mc_t[10'h085] = 16'h0085;
    rom_ma_t[10'h0A3] = 9'h090; rom_mc_t[10'h0A3] = 16'h00A3;
    rom_ma_t[10'h090] = 9'h0B0; rom_mc_t[10'h090] = 16'h8090;
    rom_ma_t[10'h0B0] = 9'h0C8; rom_mc_t[10'h0B0] = 16'h80B0;
    rom_ma_t[10'h0C8] = 9'h0D0; rom_mc_t[10'h0C8] = 16'h80C8;
    rom_mc_t[10'h0D0] = 16'hC0D0;
    rom_mc_t[10'h0C9] = 16'hC0C9;
    rom_mc_t[10'h0B1] = 16'hC0B1;
    rom_ma_t[10'h02A] = 9'h1F0; rom_mc_t[10'h02A] = 16'h802A;
    rom_ma_t[10'h0C0] = 9'h170; rom_mc_t[10'h0C0] = 16'h00C0;
    rom_mc_t[10'h370] = 16'hC370;

    reset_n = 1'b0; ax = 1'b0; stall = 1'b0; pla_valid = 1'b0;
    trap_req = 1'b0; pla_addr = 7'h00;
    mreset();
    @(negedge clk); #1;
    chk_en = 1'b1;
    idle_cycle();
    reset_n = 1'b1;
    chk("release rom_a", 32'(rif.rom_a), 32'h080);

    // NEXT chain then three nested CALLs into a 2-deep stack.
    step(1'b0, 1'b0, 1'b0, 7'h00, 1'b0);
    chk("first word", 32'(mc_out), 32'h0123);
    chk("first link", 32'(upc), 32'h085);
    step(1'b0, 1'b0, 1'b0, 7'h00, 1'b0);
    chk("chain 0A3", 32'(upc), 32'h0A3);
    step(1'b0, 1'b0, 1'b0, 7'h00, 1'b0);
    step(1'b0, 1'b0, 1'b0, 7'h00, 1'b0);
    step(1'b0, 1'b0, 1'b0, 7'h00, 1'b0);
    chk("no overflow yet", 32'(stk_err), 32'h0);
    step(1'b0, 1'b0, 1'b0, 7'h00, 1'b0);
    chk("overflow flag", 32'(stk_err), 32'h1);
    step(1'b0, 1'b0, 1'b0, 7'h00, 1'b0);
    chk("ret 0C9", 32'(upc), 32'h0C9);
    step(1'b0, 1'b0, 1'b0, 7'h00, 1'b0);
    chk("ret 0B1", 32'(upc), 32'h0B1);
    step(1'b0, 1'b0, 1'b0, 7'h00, 1'b0);
    chk("underflow vec", 32'(upc), 32'h080);
    chk("err sticky", 32'(stk_err), 32'h1);
    step(1'b0, 1'b0, 1'b0, 7'h00, 1'b0);

    // Asynchronous reset mid-run.
    reset_n = 1'b0;
    mreset();
    #1;
    chk("rst upc", 32'(upc), 32'h080);
    chk("rst mc_out", 32'(mc_out), 32'h0);
    chk("rst mc_valid", 32'(mc_valid), 32'h0);
    chk("rst stk_err", 32'(stk_err), 32'h0);
    rom_ma_t[10'h085] = 9'h1FF; rom_mc_t[10'h085] = 16'h4085;
    idle_cycle();
    reset_n = 1'b1;

    // MAP with a late PLA target.
    step(1'b0, 1'b0, 1'b0, 7'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 7'h55, 1'b0);
    end
    chk("map wait upc", 32'(upc), 32'h085);
    chk("map wait valid", 32'(mc_valid), 32'h0);
    step(1'b0, 1'b0, 1'b1, 7'h2A, 1'b0);
    chk("map target", 32'(upc), 32'h02A);

    // Trap held off by stall, then taken over a CALL word.
    step(1'b1, 1'b1, 1'b0, 7'h00, 1'b0);
    step(1'b1, 1'b1, 1'b0, 7'h00, 1'b0);
    chk("stalled trap upc", 32'(upc), 32'h02A);
    chk("stalled trap ack", 32'(trap_ack), 32'h0);
    step(1'b0, 1'b1, 1'b0, 7'h00, 1'b0);
    chk("trap vec", 32'(upc), 32'h0C0);
    chk("trap ack", 32'(trap_ack), 32'h1);
    step(1'b0, 1'b0, 1'b0, 7'h00, 1'b0);
    chk("trap ack pulse", 32'(trap_ack), 32'h0);

    // AX extension with stall hold, then RET on the (still empty) stack.
    step(1'b1, 1'b0, 1'b0, 7'h00, 1'b1);
    step(1'b1, 1'b0, 1'b0, 7'h00, 1'b1);
    chk("ax rom_a", 32'(rif.rom_a), 32'h370);
    chk("stall mc_out", 32'(mc_out), 32'h00C0);
    step(1'b0, 1'b0, 1'b0, 7'h00, 1'b1);
    chk("ax word", 32'(mc_out), 32'hC370);
    chk("empty after trap", 32'(upc), 32'h080);
    step(1'b0, 1'b0, 1'b0, 7'h00, 1'b0);
    step(1'b0, 1'b0, 1'b0, 7'h00, 1'b0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
